// File: rtl/digit_serial_adder.sv
// digit_serial_adder
//   Multi-cycle adder/subtractor. It consumes DIGIT bits of each operand per
//   clock, LSB digit first, and keeps the carry in a register between steps.
//   A full WIDTH-bit operation takes STEPS = WIDTH/DIGIT RUN cycles, followed
//   by a single DONE cycle.
// Ports
//   clk, rst          rising-edge clock, async active-high reset
//   Start             request, sampled only in IDLE
//   A, B, Cin, Sub    operands and mode, sampled with Start
//                     Sub=0 gives A+B+Cin; Sub=1 gives A-B and ignores Cin
//   Busy              high while the operation runs
//   Done              one-cycle result-valid pulse
//   Sum, Cout, Overflow  result, held until the next Done
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   step_r;
  logic             msb_cin;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    step_r  = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry_q};
    // Carry into the digit's top bit, recovered from its sum bit. This is
    // the carry into bit WIDTH-1 on the final step. It reduces to carry_q
    // when DIGIT=1.
    msb_cin = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ step_r[DIGIT-1];
    case (state_q)
      IDLE: begin
        if (Start) begin
          opa_d   = A;
          // Subtraction is A + ~B + 1.
          opb_d   = Sub ? ~B : B;
          carry_d = Sub | Cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = (res_q >> DIGIT) | (WIDTH'(step_r[DIGIT-1:0]) << (WIDTH - DIGIT));
        opa_d   = opa_q >> DIGIT;
        opb_d   = opb_q >> DIGIT;
        carry_d = step_r[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          sum_d   = res_d;
          cout_d  = step_r[DIGIT];
          ovf_d   = step_r[DIGIT] ^ msb_cin;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy     = (state_q == RUN);
  assign Done     = (state_q == DONE);
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;
endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder/subtractor, the successor to the single-bit combinational full adder. It adds two WIDTH-bit operands DIGIT bits per clock, keeping the carry in a register between steps. This trades latency for area in datapaths where a full-width ripple or carry-lookahead adder is too large. A Start/Busy/Done handshake connects it to a controlling FSM or the ALU sequencer.

## Interface
- WIDTH, 32, operand and result width in bits
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH, WIDTH mod DIGIT = 0; STEPS = WIDTH/DIGIT
- clk  in  1  clock, rising-edge active
- rst  in  1  reset, asynchronous, active-high
- Start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A, sampled with Start
- B  in  WIDTH  operand B, sampled with Start
- Cin  in  1  carry-in, sampled with Start; ignored when Sub=1
- Sub  in  1  mode, sampled with Start: 0 = A+B+Cin, 1 = A−B
- Busy  out  1  high while in RUN
- Done  out  1  one-cycle pulse, result valid
- Sum  out  WIDTH  result, held until the next Done
- Cout  out  1  carry out of the MSB; in Sub mode, 1 = no borrow (A ≥ B unsigned)
- Overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, Start=1 at an edge:
  - latch A into opA.
  - latch B into opB, or ~B if Sub=1.
  - carry reg ← Sub ? 1 : Cin.
  - step counter ← 0.
  - go to RUN.
- IDLE, Start=0: stay in IDLE.
- RUN, each edge:
  - {c, d} = opA[DIGIT−1:0] + opB[DIGIT−1:0] + carry, a (DIGIT+1)-bit result.
  - d shifts into the MSB end of the internal result register, which shifts right by DIGIT.
  - opA and opB shift right by DIGIT; carry ← c; counter increments.
- Final RUN step (counter = STEPS−1):
  - Sum ← completed result.
  - Cout ← c.
  - Overflow ← c XOR (carry into bit WIDTH−1). Track this carry internally on the final step; when DIGIT=1 it is the incoming carry reg.
  - go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally. Start is ignored in DONE.
- Start in RUN or DONE: ignored, no queuing. Changes to A, B, Cin and Sub after acceptance have no effect.
- Sum, Cout and Overflow change only on the edge entering DONE. They are stable during a following RUN.
- Arithmetic is modulo 2^WIDTH. Any carry beyond the MSB appears only on Cout.

## Timing
- Reset (async assert, any state):
  - Busy=0, Done=0, Sum=0, Cout=0, Overflow=0.
  - state IDLE; internal registers cleared.
  - An in-flight operation is aborted, and no Done is produced for it.
- Start accepted at edge k:
  - Busy=1 after edges k … k+STEPS−1, i.e. STEPS cycles.
  - Sum, Cout, Overflow and Done update at edge k+STEPS.
  - Done falls at edge k+STEPS+1, and the block returns to IDLE.
- Earliest next acceptance is edge k+STEPS+2. Maximum throughput is one operation per STEPS+2 cycles.
- Busy and Done are never high together.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=4, A=0x7F, B=0x01, Cin=0, Sub=0 -> Sum=0x80, Cout=0, Overflow=1; Busy high 2 cycles; Done 2 edges after Start.
- WIDTH=8, DIGIT=4, A=0xFF, B=0x01, Cin=1, Sub=0 -> Sum=0x01, Cout=1, Overflow=0.
- WIDTH=8, DIGIT=1, Sub=1:
  - A=0x05, B=0x07 -> Sum=0xFE, Cout=0, Overflow=0.
  - A=0x80, B=0x01 -> Sum=0x7F, Cout=1, Overflow=1.
  - In both cases Done comes 8 edges after Start, and Cin=1 is ignored.
- Start=1 with A=0x10, B=0x20; pulse Start again mid-RUN with A=0xAA, B=0x55 -> second request ignored; Sum=0x30, single Done pulse.
- rst asserted mid-RUN after a prior result 0x30 -> Sum, Cout, Overflow, Busy and Done go to 0 immediately; no Done pulse; a fresh Start after release completes normally.
- Start held high for 3 operations with WIDTH=8, DIGIT=4 -> Done pulses exactly 4 cycles apart; each result matches its operands sampled at acceptance.
